uart_frame_scheduler: RTL

Sequences framed telemetry packets into the Duplex UART transmitter on the 1 MHz domain.

---
 rtl/uart_frame_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_frame_scheduler                                             |
// | Purpose : Round-robin framing of vitals/temperature packets into the UART. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_frame_scheduler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] ID_VITALS      = 8'h01,
  parameter logic [7:0] ID_TEMP        = 8'h02,
  parameter int         TIMEOUT_CYCLES = 20000,
  parameter int         TO_W           = 15
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        vitals_req,
  input  logic [15:0] vitals_hr,
  input  logic [7:0]  vitals_spo2,
  input  logic        temp_req,
  input  logic [15:0] temp_value,
  output logic        vitals_ack,
  output logic        temp_ack,
  output logic        uart_send,
  output logic [7:0]  uart_data,
  input  logic        uart_tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_GRANT = 3'd1;
  localparam logic [2:0] c_S_SEND  = 3'd2;
  localparam logic [2:0] c_S_WAIT  = 3'd3;
  localparam logic [2:0] c_S_NEXT  = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;

  localparam logic c_SRC_VITALS = 1'b0;
  localparam logic c_SRC_TEMP   = 1'b1;

  localparam logic [7:0]      c_EOF_BYTE = 8'h0A;
  localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] c_TO_ONE   = TO_W'(1);

  logic [2:0]      r_state;
  logic [2:0]      r_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_last_grant;
  logic            r_type;
  logic [15:0]     r_hr;
  logic [7:0]      r_spo2;
  logic [15:0]     r_temp;
  logic [7:0]      r_uart_data;
  logic            r_timeout_err;

  logic            w_pick_temp;
  logic [2:0]      w_sel_idx;
  logic [7:0]      w_chk;
  logic [7:0]      w_next_byte;
  logic            w_last_byte;
  logic [TO_W-1:0] w_to_inc;

  // On a tie the requester that did not win last time is served.
  assign w_pick_temp = temp_req && (!vitals_req || (r_last_grant == c_SRC_VITALS));
  assign w_to_inc    = r_to_cnt + c_TO_ONE;

  always_comb begin
    w_sel_idx   = (r_state == c_S_GRANT) ? 3'd0 : r_idx + 3'd1;
    w_chk       = 8'h00;
    w_next_byte = c_EOF_BYTE;
    w_last_byte = 1'b0;
    if (r_type == c_SRC_VITALS) begin
      w_chk       = ID_VITALS + r_hr[7:0] + r_hr[15:8] + r_spo2;
      w_last_byte = (r_idx == 3'd6);
      case (w_sel_idx)
        3'd0:    w_next_byte = SYNC_BYTE;
        3'd1:    w_next_byte = ID_VITALS;
        3'd2:    w_next_byte = r_hr[7:0];
        3'd3:    w_next_byte = r_hr[15:8];
        3'd4:    w_next_byte = r_spo2;
        3'd5:    w_next_byte = w_chk;
        default: w_next_byte = c_EOF_BYTE;
      endcase
    end else begin
      w_chk       = ID_TEMP + r_temp[7:0] + r_temp[15:8];
      w_last_byte = (r_idx == 3'd5);
      case (w_sel_idx)
        3'd0:    w_next_byte = SYNC_BYTE;
        3'd1:    w_next_byte = ID_TEMP;
        3'd2:    w_next_byte = r_temp[7:0];
        3'd3:    w_next_byte = r_temp[15:8];
        3'd4:    w_next_byte = w_chk;
        default: w_next_byte = c_EOF_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      r_state       <= c_S_IDLE;
      r_idx         <= 3'd0;
      r_to_cnt      <= '0;
      r_last_grant  <= c_SRC_TEMP;
      r_type        <= c_SRC_VITALS;
      r_hr          <= 16'h0000;
      r_spo2        <= 8'h00;
      r_temp        <= 16'h0000;
      r_uart_data   <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (vitals_req || temp_req) begin
            r_state      <= c_S_GRANT;
            r_type       <= w_pick_temp ? c_SRC_TEMP : c_SRC_VITALS;
            r_last_grant <= w_pick_temp ? c_SRC_TEMP : c_SRC_VITALS;
            if (w_pick_temp) begin
              r_temp <= temp_value;
            end else begin
              r_hr   <= vitals_hr;
              r_spo2 <= vitals_spo2;
            end
          end
        end
        c_S_GRANT: begin
          r_idx       <= 3'd0;
          r_uart_data <= w_next_byte;
          r_state     <= c_S_SEND;
        end
        c_S_SEND: begin
          r_to_cnt <= '0;
          r_state  <= c_S_WAIT;
        end
        c_S_WAIT: begin
          r_to_cnt <= w_to_inc;
          if (uart_tx_done) begin
            r_state <= w_last_byte ? c_S_DONE : c_S_NEXT;
          end else if (w_to_inc == c_TO_LIMIT) begin
            // Frame is dropped outright; the requester must ask again.
            r_timeout_err <= 1'b1;
            r_idx         <= 3'd0;
            r_state       <= c_S_IDLE;
          end
        end
        c_S_NEXT: begin
          r_idx       <= r_idx + 3'd1;
          r_uart_data <= w_next_byte;
          r_state     <= c_S_SEND;
        end
        c_S_DONE: begin
          r_idx   <= 3'd0;
          r_state <= c_S_IDLE;
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  assign vitals_ack  = (r_state == c_S_GRANT) && (r_type == c_SRC_VITALS);
  assign temp_ack    = (r_state == c_S_GRANT) && (r_type == c_SRC_TEMP);
  assign uart_send   = (r_state == c_S_SEND);
  assign busy        = (r_state == c_S_GRANT) || (r_state == c_S_SEND) ||
                       (r_state == c_S_WAIT)  || (r_state == c_S_NEXT);
  assign frame_done  = (r_state == c_S_DONE);
  assign timeout_err = r_timeout_err;
  assign uart_data   = r_uart_data;

endmodule
`default_nettype wire
